output_buffer: RTL and testbench

- Memory-mapped output peripheral, the store-side counterpart of the switch input synchronizer.
- The LSU writes and reads back the registered values that drive the board outputs: red LEDs, green LEDs, eight 7-segment displays and the character LCD.
- All outputs come straight from flops, so the pins stay glitch-free.
- LCD writes go through a timed enable-pulse FSM that back-pressures the LSU with o_ready.

---
 rtl/output_buffer_pkg.sv | 42 ++++
 rtl/lcd_pulse_gen.sv | 97 +++++++++
 rtl/output_buffer.sv | 143 ++++++++++++++
 tb/tb_output_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_pkg.sv
// Shared definitions for the output_buffer peripheral.
//   - region selects decoded from i_addr[15:12]
//   - bit positions inside the LCD bus word
//   - LCD enable-pulse FSM states
//   - byte-lane merge helper used by every writable register
package output_buffer_pkg;

  localparam logic [3:0] ADDR_LEDR   = 4'h0;
  localparam logic [3:0] ADDR_LEDG   = 4'h1;
  localparam logic [3:0] ADDR_HEX_LO = 4'h2;
  localparam logic [3:0] ADDR_HEX_HI = 4'h3;
  localparam logic [3:0] ADDR_LCD    = 4'h4;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RS_BIT = 9;
  localparam int LCD_RW_BIT = 8;

  // Bits of the LCD word that software can actually store. EN is owned by
  // the pulse FSM, and the unused gap bits always read as zero.
  localparam logic [31:0] LCD_STORE_MASK = (32'h1 << LCD_ON_BIT) |
                                           (32'h1 << LCD_RS_BIT) |
                                           (32'h1 << LCD_RW_BIT) |
                                           32'h0000_00FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } lcd_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  bmask);
    logic [31:0] res;
    for (int n = 0; n < 4; n++)
      res[8*n +: 8] = bmask[n] ? wdata[8*n +: 8] : old_val[8*n +: 8];
    return res;
  endfunction

endpackage

// File: rtl/lcd_pulse_gen.sv
// LCD enable-pulse sequencer.
// A start pulse walks the FSM through SETUP -> PULSE -> HOLD -> IDLE, with a
// single shared down-counter reloaded on every state entry.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_start  one-cycle start request (only honoured in IDLE)
//   o_en     LCD EN strobe, high for PULSE_CYC cycles
//   o_busy   high whenever the FSM is outside IDLE
// Both outputs are flops so the LCD pins see no decode glitches.
module lcd_pulse_gen
  import output_buffer_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 25,
  parameter int HOLD_CYC  = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  output logic o_en,
  output logic o_busy
);

  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  // A state lasting N cycles is entered with N-1 and leaves when it hits 0.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  lcd_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_en, r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = SETUP_LD;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = HOLD_LD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Outputs registered from the next state so they line up with r_state.
      r_en    <= (w_state_nxt == PULSE);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign o_en   = r_en;
  assign o_busy = r_busy;

endmodule

// File: rtl/output_buffer.sv
// Memory-mapped board output peripheral (LEDs, 7-segment, character LCD).
// Build option: define OUTPUT_BUFFER_HEX_ACTIVE_LOW_EN to drive the hex
// segment pins inverted (common-anode displays); readback stays non-inverted.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_wren/i_rden           write / read request (writes qualified by o_ready)
//   i_addr[15:12]           region select, low 12 bits ignored
//   i_wdata, i_bmask        write data and byte-lane enables
//   o_rdata, o_rvalid       readback, one cycle after i_rden
//   o_ready                 low while an LCD transfer is in flight
//   o_io_ledr, o_io_ledg    LED registers
//   o_io_hex0..o_io_hex7    segment patterns
//   o_io_lcd                {ON[31], EN[10], RS[9], RW[8], DATA[7:0]}
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int LCD_SETUP_CYC = 4,
  parameter int LCD_PULSE_CYC = 25,
  parameter int LCD_HOLD_CYC  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wren,
  input  logic        i_rden,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_ready,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

`ifdef OUTPUT_BUFFER_HEX_ACTIVE_LOW_EN
  localparam logic [6:0] HEX_POL = 7'h7F;
`else
  localparam logic [6:0] HEX_POL = 7'h00;
`endif

  logic [31:0] r_ledr, r_ledg, r_hex_lo, r_hex_hi, r_lcd;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic [3:0]  w_sel;
  logic        w_wr_acc, w_lcd_start;
  logic        w_lcd_en, w_lcd_busy;
  logic [31:0] w_lcd_bus, w_rd_mux;
  logic [7:0][6:0] w_hex;
  logic        w_addr_unused;

  assign w_sel         = i_addr[15:12];
  assign w_addr_unused = ^i_addr[11:0];

  // Every write stalls while the LCD sequencer runs; the LSU holds the request.
  assign o_ready     = ~w_lcd_busy;
  assign w_wr_acc    = i_wren & o_ready;
  assign w_lcd_start = w_wr_acc && (w_sel == ADDR_LCD) && (|i_bmask);

  lcd_pulse_gen #(
    .SETUP_CYC (LCD_SETUP_CYC),
    .PULSE_CYC (LCD_PULSE_CYC),
    .HOLD_CYC  (LCD_HOLD_CYC)
  ) u_lcd_pulse_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_lcd_start),
    .o_en    (w_lcd_en),
    .o_busy  (w_lcd_busy)
  );

  // EN comes from the live FSM, never from the stored word.
  assign w_lcd_bus = r_lcd | (32'(w_lcd_en) << LCD_EN_BIT);

  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      ADDR_LEDR:   w_rd_mux = r_ledr;
      ADDR_LEDG:   w_rd_mux = r_ledg;
      ADDR_HEX_LO: w_rd_mux = r_hex_lo;
      ADDR_HEX_HI: w_rd_mux = r_hex_hi;
      ADDR_LCD:    w_rd_mux = w_lcd_bus;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ledr   <= '0;
      r_ledg   <= '0;
      r_hex_lo <= '0;
      r_hex_hi <= '0;
      r_lcd    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        case (w_sel)
          ADDR_LEDR:   r_ledr   <= byte_merge(r_ledr, i_wdata, i_bmask);
          ADDR_LEDG:   r_ledg   <= byte_merge(r_ledg, i_wdata, i_bmask);
          ADDR_HEX_LO: r_hex_lo <= byte_merge(r_hex_lo, i_wdata, i_bmask);
          ADDR_HEX_HI: r_hex_hi <= byte_merge(r_hex_hi, i_wdata, i_bmask);
          ADDR_LCD:    r_lcd    <= byte_merge(r_lcd, i_wdata, i_bmask) & LCD_STORE_MASK;
          default: ;
        endcase
      end
      // Readback samples pre-write state, so a same-cycle write reads old data.
      r_rvalid <= i_rden;
      r_rdata  <= i_rden ? w_rd_mux : '0;
    end
  end

  // Segment bit 7 of each byte is kept for readback only.
  for (genvar n = 0; n < 4; n++) begin : g_hex
    assign w_hex[n]   = r_hex_lo[8*n +: 7] ^ HEX_POL;
    assign w_hex[n+4] = r_hex_hi[8*n +: 7] ^ HEX_POL;
  end

  assign o_io_hex0 = w_hex[0];
  assign o_io_hex1 = w_hex[1];
  assign o_io_hex2 = w_hex[2];
  assign o_io_hex3 = w_hex[3];
  assign o_io_hex4 = w_hex[4];
  assign o_io_hex5 = w_hex[5];
  assign o_io_hex6 = w_hex[6];
  assign o_io_hex7 = w_hex[7];

  assign o_io_ledr = r_ledr;
  assign o_io_ledg = r_ledg;
  assign o_io_lcd  = w_lcd_bus;
  assign o_rdata   = r_rdata;
  assign o_rvalid  = r_rvalid;

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed writes with output checks,
// reads compared against a scoreboard queue filled at issue time.
module tb_output_buffer;

  logic        clk, rst;
  logic        i_wren, i_rden;
  logic [15:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_bmask;
  logic [31:0] o_rdata, o_io_ledr, o_io_ledg, o_io_lcd;
  logic        o_rvalid, o_ready;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];

  output_buffer #(
    .LCD_SETUP_CYC (4),
    .LCD_PULSE_CYC (25),
    .LCD_HOLD_CYC  (4)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wren    (i_wren),
    .i_rden    (i_rden),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_bmask   (i_bmask),
    .o_rdata   (o_rdata),
    .o_rvalid  (o_rvalid),
    .o_ready   (o_ready),
    .o_io_ledr (o_io_ledr),
    .o_io_ledg (o_io_ledg),
    .o_io_hex0 (o_io_hex0),
    .o_io_hex1 (o_io_hex1),
    .o_io_hex2 (o_io_hex2),
    .o_io_hex3 (o_io_hex3),
    .o_io_hex4 (o_io_hex4),
    .o_io_hex5 (o_io_hex5),
    .o_io_hex6 (o_io_hex6),
    .o_io_hex7 (o_io_hex7),
    .o_io_lcd  (o_io_lcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hx(input logic [6:0] v);
`ifdef OUTPUT_BUFFER_HEX_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Scoreboard consumer: every readback must match the oldest expectation.
  always @(negedge clk) begin
    if (o_rvalid) begin
      if (sb_q.size() == 0) chk("rd_spurious", 32'(o_rvalid), 32'd0);
      else                  chk("rd_data", o_rdata, sb_q.pop_front());
    end
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    i_wren = 1'b1; i_addr = a; i_wdata = d; i_bmask = m;
    @(posedge clk); #1;
    i_wren = 1'b0; i_bmask = 4'h0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e);
    @(negedge clk);
    i_rden = 1'b1; i_addr = a; sb_q.push_back(e);
    @(posedge clk); #1;
    i_rden = 1'b0;
  endtask

  int n_rdy_lo, n_en, first_en, lcd_bad;

  initial begin
    rst = 1'b1; i_wren = 1'b0; i_rden = 1'b0;
    i_addr = '0; i_wdata = '0; i_bmask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ledr", o_io_ledr, 32'h0);
    chk("rst_ledg", o_io_ledg, 32'h0);
    chk("rst_lcd", o_io_lcd, 32'h0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_hex0", 32'(o_io_hex0), 32'(hx(7'h00)));
    chk("rst_hex7", 32'(o_io_hex7), 32'(hx(7'h00)));

    // Full write + readback
    wr(16'h0000, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk); chk("ledr_full", o_io_ledr, 32'hDEAD_BEEF);
    rd(16'h0000, 32'hDEAD_BEEF);

    // Byte-lane merge (low address bits ignored), then empty mask
    wr(16'h0ABC, 32'h0000_1200, 4'b0010);
    @(negedge clk); chk("ledr_lane1", o_io_ledr, 32'hDEAD_12EF);
    wr(16'h0000, 32'hFFFF_FFFF, 4'h0);
    @(negedge clk); chk("ledr_mask0", o_io_ledr, 32'hDEAD_12EF);

    // Same-cycle read and write returns the old value
    @(negedge clk);
    i_wren = 1'b1; i_rden = 1'b1; i_addr = 16'h0000;
    i_wdata = 32'h1111_1111; i_bmask = 4'hF;
    sb_q.push_back(32'hDEAD_12EF);
    @(posedge clk); #1;
    i_wren = 1'b0; i_rden = 1'b0; i_bmask = 4'h0;
    @(negedge clk); chk("ledr_rw", o_io_ledr, 32'h1111_1111);

    // HEX_HI with bit 7 set in byte 3: stored but not driven
    wr(16'h3000, 32'hFF40_0079, 4'hF);
    @(negedge clk);
    chk("hex7", 32'(o_io_hex7), 32'(hx(7'h7F)));
    chk("hex6", 32'(o_io_hex6), 32'(hx(7'h40)));
    chk("hex5", 32'(o_io_hex5), 32'(hx(7'h00)));
    chk("hex4", 32'(o_io_hex4), 32'(hx(7'h79)));
    rd(16'h3000, 32'hFF40_0079);

    wr(16'h2000, 32'h003F_065B, 4'hF);
    @(negedge clk);
    chk("hex0", 32'(o_io_hex0), 32'(hx(7'h5B)));
    chk("hex1", 32'(o_io_hex1), 32'(hx(7'h06)));
    chk("hex2", 32'(o_io_hex2), 32'(hx(7'h3F)));
    chk("hex3", 32'(o_io_hex3), 32'(hx(7'h00)));

    // Unmapped accesses
    rd(16'h7000, 32'h0);
    wr(16'h9000, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk("unmap_ledr", o_io_ledr, 32'h1111_1111);
    chk("unmap_ledg", o_io_ledg, 32'h0);
    chk("unmap_lcd", o_io_lcd, 32'h0);
    chk("unmap_hex4", 32'(o_io_hex4), 32'(hx(7'h79)));

    // LCD transfer with a LEDG write queued behind it
    @(negedge clk);
    i_wren = 1'b1; i_addr = 16'h4000; i_wdata = 32'h8000_0241; i_bmask = 4'hF;
    @(posedge clk); #1;
    i_addr = 16'h1000; i_wdata = 32'hCAFE_F00D;
    n_rdy_lo = 0; n_en = 0; first_en = 0; lcd_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) begin i_rden = 1'b1; sb_q.push_back(32'h0); end
      if (k == 11) i_rden = 1'b0;
      if (!o_ready) n_rdy_lo++;
      if (o_io_lcd[10]) begin
        n_en++;
        if (first_en == 0) first_en = k;
      end
      if (k <= 33 && (o_io_lcd & 32'h8000_03FF) !== 32'h8000_0241) lcd_bad++;
      if (k == 33) chk("ledg_stalled", o_io_ledg, 32'h0);
      if (k == 35) chk("ledg_after", o_io_ledg, 32'hCAFE_F00D);
      if (o_ready && i_wren) begin
        @(posedge clk); #1;
        i_wren = 1'b0; i_bmask = 4'h0;
      end
    end
    chk("lcd_busy_cycles", 32'(n_rdy_lo), 32'd33);
    chk("lcd_en_cycles", 32'(n_en), 32'd25);
    chk("lcd_en_first", 32'(first_en), 32'd5);
    chk("lcd_bus_stable", 32'(lcd_bad), 32'd0);
    if (i_wren) begin
      chk("ledg_timeout", 32'd1, 32'd0);
      i_wren = 1'b0;
    end
    chk("lcd_idle", o_io_lcd, 32'h8000_0241);
    rd(16'h4000, 32'h8000_0241);

    // ON=0 and software EN bit set: sequence still runs, reset kills it mid-PULSE
    wr(16'h4000, 32'h0000_0455, 4'hF);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        i_rden = 1'b1; i_addr = 16'h4000; sb_q.push_back(32'h0000_0455);
      end
      if (k == 10) i_rden = 1'b0;
    end
    chk("lcd_mid", o_io_lcd, 32'h0000_0455);
    chk("ready_mid", 32'(o_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rrst_lcd", o_io_lcd, 32'h0);
    chk("rrst_ready", 32'(o_ready), 32'd1);
    chk("rrst_ledr", o_io_ledr, 32'h0);
    chk("rrst_ledg", o_io_ledg, 32'h0);
    chk("rrst_hex4", 32'(o_io_hex4), 32'(hx(7'h00)));
    chk("rrst_rvalid", 32'(o_rvalid), 32'd0);

    wr(16'h0000, 32'h5A5A_5A5A, 4'hF);
    @(negedge clk); chk("post_rst_wr", o_io_ledr, 32'h5A5A_5A5A);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
